// File: rtl/uart_tx.sv
// uart_tx: serialises bytes from a FIFO-like source onto a single TX line.
// Frame: start bit (0), 8 data bits LSB first, optional parity, 1 or 2 stop
// bits (1). The source presents a byte with dval_in; den_out pulses for one
// cycle when the byte is taken. When dval_in is high at the end of a stop
// period, the next frame starts with no idle gap.

module uart_tx #(
    parameter int CLKS_PER_BIT = 1736,  // clock cycles per bit, >= 2
    parameter int PARITY       = 0,     // 0 = none, 1 = odd, 2 = even
    parameter int STOP_BITS    = 1      // 1 or 2
) (
    input  logic       clk,
    input  logic       rst,       // asynchronous, active-low
    input  logic [7:0] din,
    input  logic       dval_in,
    output logic       den_out,
    output logic       txd_out,
    output logic       idle_out
);

    localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit                HAS_PARITY = (PARITY != 0);
    localparam logic              PAR_ODD    = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;   // data bit index in DATA, stop bit index in STOP
    logic [7:0]        shift_reg;
    logic              par_bit;   // parity computed once at load time

    logic baud_done;
    logic load;

    // Terminal count of the current bit period (never in IDLE).
    assign baud_done = (state != S_IDLE) && (baud_cnt == BAUD_LAST);

    // A byte is taken either from IDLE or on the last cycle of the stop period.
    assign load = dval_in &&
                  ((state == S_IDLE) ||
                   ((state == S_STOP) && baud_done && (bit_cnt == STOP_LAST)));

    // Frame sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            den_out   <= 1'b0;
            txd_out   <= 1'b1;
            idle_out  <= 1'b1;
        end else begin
            // NOTE: every register here uses <= so all branches see the values
            // from before this edge; a blocking = would let later reads in the
            // same block observe half-updated state and break the register model.
            den_out <= load;

            if (load) begin
                // The first start-bit cycle coincides with the den_out pulse.
                state     <= S_START;
                shift_reg <= din;
                par_bit   <= (^din) ^ PAR_ODD;
                baud_cnt  <= '0;
                bit_cnt   <= '0;
                txd_out   <= 1'b0;
                idle_out  <= 1'b0;
            end else if (state == S_IDLE) begin
                baud_cnt <= '0;
                txd_out  <= 1'b1;
                idle_out <= 1'b1;
            end else if (!baud_done) begin
                baud_cnt <= baud_cnt + 1'b1;
            end else begin
                baud_cnt <= '0;
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        txd_out <= shift_reg[0];
                    end
                    S_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                state   <= S_PARITY;
                                txd_out <= par_bit;
                            end else begin
                                state   <= S_STOP;
                                txd_out <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            txd_out   <= shift_reg[1];
                        end
                    end
                    S_PARITY: begin
                        state   <= S_STOP;
                        bit_cnt <= '0;
                        txd_out <= 1'b1;
                    end
                    S_STOP: begin
                        // Last stop cycle without a pending byte ends in IDLE;
                        // with a pending byte the load branch above takes over.
                        if (bit_cnt == STOP_LAST) begin
                            state    <= S_IDLE;
                            bit_cnt  <= '0;
                            txd_out  <= 1'b1;
                            idle_out <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        txd_out  <= 1'b1;
                        idle_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed plus randomized checks of uart_tx in three
// configurations (no parity / even parity / odd parity with two stop bits).
// The expected line level is derived from the frame layout: cycle k of a frame
// lies in slot k / CLKS_PER_BIT, which is start, data bit, parity or stop.

module tb_uart_tx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       dval0, dval_e, dval_o;
    logic       den0, txd0, idle0;
    logic       den_e, txd_e, idle_e;
    logic       den_o, txd_o, idle_o;

    int n_assert = 0;
    int n_fail   = 0;
    int den0_count = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .din(din), .dval_in(dval0),
        .den_out(den0), .txd_out(txd0), .idle_out(idle0)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst(rst), .din(din), .dval_in(dval_e),
        .den_out(den_e), .txd_out(txd_e), .idle_out(idle_e)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut_odd (
        .clk(clk), .rst(rst), .din(din), .dval_in(dval_o),
        .den_out(den_o), .txd_out(txd_o), .idle_out(idle_o)
    );

    // Counts den_out pulses of the no-parity instance.
    always @(negedge clk) if (den0 === 1'b1) den0_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cfg_parity(input int cfg);
        case (cfg)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_stops(input int cfg);
        return (cfg == 2) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int cfg);
        return (1 + 8 + ((cfg_parity(cfg) != 0) ? 1 : 0) + cfg_stops(cfg)) * CPB;
    endfunction

    // Reference line level at cycle k of a frame carrying byte b.
    function automatic logic model_txd(input int cfg, input logic [7:0] b, input int k);
        int slot;
        int par;
        slot = k / CPB;
        par  = cfg_parity(cfg);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (par != 0 && slot == 9)
            return ($countones(b) % 2 == 1) ? (par == 2) : (par == 1);
        return 1'b1;
    endfunction

    // {den_out, txd_out, idle_out} of the selected instance.
    function automatic logic [2:0] outs(input int cfg);
        case (cfg)
            1:       return {den_e, txd_e, idle_e};
            2:       return {den_o, txd_o, idle_o};
            default: return {den0, txd0, idle0};
        endcase
    endfunction

    task automatic set_dval(input int cfg, input logic v);
        case (cfg)
            1:       dval_e = v;
            2:       dval_o = v;
            default: dval0  = v;
        endcase
    endtask

    // Called at the negedge of frame cycle 0; returns at the negedge of the
    // last frame cycle. din is changed to new_din at cycle change_at.
    task automatic check_frame(input int cfg, input logic [7:0] b, input int change_at,
                               input logic [7:0] new_din, input string tag);
        int         len;
        logic [2:0] o;
        len = frame_len(cfg);
        for (int k = 0; k < len; k++) begin
            o = outs(cfg);
            check($sformatf("%s txd k=%0d", tag, k), {31'd0, o[1]}, {31'd0, model_txd(cfg, b, k)});
            check($sformatf("%s den k=%0d", tag, k), {31'd0, o[2]}, (k == 0) ? 32'd1 : 32'd0);
            check($sformatf("%s idle k=%0d", tag, k), {31'd0, o[0]}, 32'd0);
            if (k == change_at) din = new_din;
            if (k < len - 1) @(negedge clk);
        end
    endtask

    task automatic check_idle(input int cfg, input string tag);
        logic [2:0] o;
        o = outs(cfg);
        check({tag, " idle"}, {31'd0, o[0]}, 32'd1);
        check({tag, " txd"},  {31'd0, o[1]}, 32'd1);
        check({tag, " den"},  {31'd0, o[2]}, 32'd0);
    endtask

    // Single frame with a one-cycle dval_in pulse, followed by an idle check.
    task automatic send(input int cfg, input logic [7:0] b, input int change_at,
                        input logic [7:0] new_din, input string tag);
        din = b;
        set_dval(cfg, 1'b1);
        @(negedge clk);
        set_dval(cfg, 1'b0);
        check_frame(cfg, b, change_at, new_din, tag);
        @(negedge clk);
        check_idle(cfg, {tag, " end"});
    endtask

    initial begin
        string      msg;
        logic [7:0] r;
        logic [7:0] nxt;
        int         snap;
        int         cfg;

        msg    = "helloworld";
        rst    = 1'b0;
        din    = 8'h00;
        dval0  = 1'b0;
        dval_e = 1'b0;
        dval_o = 1'b0;

        // Reset held with a valid byte offered: nothing may start.
        din   = 8'h68;
        dval0 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_idle(0, "reset_hold");
        end
        dval0 = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check_idle(0, "after_reset");

        // Single frame of 8'h68; din changed one cycle after den_out.
        send(0, 8'h68, 1, 8'($urandom), "t2_68");
        repeat (3) begin
            @(negedge clk);
            check_idle(0, "t2_gap");
        end

        // Back-to-back "helloworld" with dval_in held high.
        snap  = den0_count;
        din   = msg[0];
        dval0 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            nxt = (i < 9) ? msg[i+1] : 8'($urandom);
            if (i == 9) dval0 = 1'b0;
            check_frame(0, msg[i], 0, nxt, $sformatf("t3_b%0d", i));
            @(negedge clk);
        end
        check_idle(0, "t3_end");
        check("t3_den_pulses", den0_count - snap, 32'd10);

        // Even parity of 8'h6c.
        send(1, 8'h6c, 1, 8'($urandom), "t4_even");

        // Odd parity, two stop bits, back-to-back pair.
        din    = 8'h6c;
        dval_o = 1'b1;
        @(negedge clk);
        r = 8'($urandom);
        check_frame(2, 8'h6c, 0, r, "t4_odd0");
        @(negedge clk);
        dval_o = 1'b0;
        check_frame(2, r, 3, 8'($urandom), "t4_odd1");
        @(negedge clk);
        check_idle(2, "t4_odd_end");

        // Reset asserted during the data bits of 8'h65.
        din   = 8'h65;
        dval0 = 1'b1;
        @(negedge clk);
        dval0 = 1'b0;
        repeat (16 * 3 + 5) @(negedge clk);
        check("t5_mid_data", {31'd0, txd0}, {31'd0, model_txd(0, 8'h65, 16 * 3 + 5)});
        rst = 1'b0;
        #1;
        check_idle(0, "t5_async");
        dval0 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle(0, "t5_held");
        end
        r   = 8'($urandom);
        din = r;
        rst = 1'b1;
        @(negedge clk);
        dval0 = 1'b0;
        check_frame(0, r, 2, 8'($urandom), "t5_fresh");
        @(negedge clk);
        check_idle(0, "t5_end");

        // din changes right after den_out; frame must carry the loaded byte.
        send(0, 8'h3c, 1, 8'hc3, "t6_din_change");

        // Randomized frames across all three configurations.
        for (int i = 0; i < 8; i++) begin
            cfg = int'($urandom_range(0, 2));
            r   = 8'($urandom);
            send(cfg, r, int'($urandom_range(0, 20)), 8'($urandom), $sformatf("rnd%0d_c%0d", i, cfg));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
